// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs, branch/stall feedback and MEM/WB outputs of the memory stage.
// MISALIGN_TRAP_EN adds the mem_misalign flag.
interface mem_stage_if;
  logic [1:0]  MEM_ctlwb;
  logic [2:0]  MEM_ctlm;
  logic [31:0] MEM_alu_out;
  logic [31:0] MEM_rd2;
  logic        MEM_alu_zero;
  logic [4:0]  MEM_rd;
  logic        MEM_PCSrc;
  logic        mem_stall;
  logic [1:0]  WB_ctlwb;
  logic [31:0] WB_rdata;
  logic [31:0] WB_alu_out;
  logic [4:0]  WB_rd;
`ifdef MISALIGN_TRAP_EN
  logic        mem_misalign;
  modport master(output MEM_ctlwb, MEM_ctlm, MEM_alu_out, MEM_rd2, MEM_alu_zero, MEM_rd,
                 input MEM_PCSrc, mem_stall, WB_ctlwb, WB_rdata, WB_alu_out, WB_rd, mem_misalign);
  modport slave(input MEM_ctlwb, MEM_ctlm, MEM_alu_out, MEM_rd2, MEM_alu_zero, MEM_rd,
                output MEM_PCSrc, mem_stall, WB_ctlwb, WB_rdata, WB_alu_out, WB_rd, mem_misalign);
`else
  modport master(output MEM_ctlwb, MEM_ctlm, MEM_alu_out, MEM_rd2, MEM_alu_zero, MEM_rd,
                 input MEM_PCSrc, mem_stall, WB_ctlwb, WB_rdata, WB_alu_out, WB_rd);
  modport slave(input MEM_ctlwb, MEM_ctlm, MEM_alu_out, MEM_rd2, MEM_alu_zero, MEM_rd,
                output MEM_PCSrc, mem_stall, WB_ctlwb, WB_rdata, WB_alu_out, WB_rd);
`endif
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage - data memory, branch resolve, optional wait states, MEM/WB register.
// Optional MISALIGN_TRAP_EN: flags and suppresses accesses with non-zero low address bits.
module mem_stage #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input logic clk,
  input logic rst_n,
  mem_stage_if.slave bus
);
  localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic access, last, done, stall, mis, we;
  logic [1:0] wb_ctlwb_q;
  logic [31:0] wb_rdata_q, wb_alu_q;
  logic [4:0] wb_rd_q;
  assign idx = bus.MEM_alu_out[ADDR_W+1:2];
  assign access = bus.MEM_ctlm[1] | bus.MEM_ctlm[0];
  assign last = state_q == BUSY && cnt_q == CW'(1);
`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  assign mis = bus.MEM_alu_out[1:0] != 2'b00;
  assign bus.mem_misalign = misalign_q;
`else
  assign mis = 1'b0;
`endif
  // stall covers the entering cycle and all BUSY cycles but the final one
  assign stall = WAIT_STATES > 0 && rst_n && ((state_q == IDLE && access) || (state_q == BUSY && !last));
  assign done = access && (WAIT_STATES == 0 || last);
  assign we = rst_n && done && bus.MEM_ctlm[0] && !mis;
  assign bus.mem_stall = stall;
  assign bus.MEM_PCSrc = rst_n & bus.MEM_ctlm[2] & bus.MEM_alu_zero;
  assign bus.WB_ctlwb = wb_ctlwb_q;
  assign bus.WB_rdata = wb_rdata_q;
  assign bus.WB_alu_out = wb_alu_q;
  assign bus.WB_rd = wb_rd_q;
  always_comb begin
    state_d = state_q == IDLE ? (stall ? BUSY : IDLE) : (last ? IDLE : BUSY);
    cnt_d = state_q == IDLE ? (stall ? CW'(WAIT_STATES) : cnt_q) : cnt_q - CW'(1);
  end
  always_ff @(posedge clk)
    if (we) mem[idx] <= bus.MEM_rd2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wb_ctlwb_q <= '0;
      wb_rdata_q <= '0;
      wb_alu_q <= '0;
      wb_rd_q <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wb_ctlwb_q <= (stall || (mis && done && bus.MEM_ctlm[1])) ? 2'b00 : bus.MEM_ctlwb;
      if (!stall) begin
        wb_rdata_q <= mem[idx];
        wb_alu_q <= bus.MEM_alu_out;
        wb_rd_q <= bus.MEM_rd;
      end
`ifdef MISALIGN_TRAP_EN
      misalign_q <= done && mis;
`endif
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table plus randomized model checks of mem_stage with 0, 2 and 3 wait states.
module tb_mem_stage;
  logic clk = 1'b0, rst_n = 1'b0, rst3 = 1'b0;
  always #5 clk = ~clk;
  mem_stage_if b0(), b2(), b3();
  mem_stage #(.WAIT_STATES(0)) d0(.clk(clk), .rst_n(rst_n), .bus(b0));
  mem_stage #(.WAIT_STATES(2)) d2(.clk(clk), .rst_n(rst_n), .bus(b2));
  mem_stage #(.WAIT_STATES(3)) d3(.clk(clk), .rst_n(rst3), .bus(b3));

  typedef struct packed {
    logic pc, st;
    logic [1:0] cw;
    logic [31:0] rdat, alu;
    logic [4:0] rd;
  } out_t;
  typedef struct {
    logic [1:0] cw; logic [2:0] cm; logic [31:0] a, d; logic z; logic [4:0] r;
    logic e_pc; logic [1:0] e_cw; logic rchk; logic [31:0] e_rdat;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  logic [31:0] m [4][256];
  bit v [4][256];
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic [1:0] cw, input logic [2:0] cm, input logic [31:0] a,
                       input logic [31:0] d, input logic z, input logic [4:0] r);
    case (s)
      0: begin b0.MEM_ctlwb = cw; b0.MEM_ctlm = cm; b0.MEM_alu_out = a; b0.MEM_rd2 = d; b0.MEM_alu_zero = z; b0.MEM_rd = r; end
      2: begin b2.MEM_ctlwb = cw; b2.MEM_ctlm = cm; b2.MEM_alu_out = a; b2.MEM_rd2 = d; b2.MEM_alu_zero = z; b2.MEM_rd = r; end
      default: begin b3.MEM_ctlwb = cw; b3.MEM_ctlm = cm; b3.MEM_alu_out = a; b3.MEM_rd2 = d; b3.MEM_alu_zero = z; b3.MEM_rd = r; end
    endcase
  endtask

  function automatic out_t outs(input int s);
    case (s)
      0: return '{b0.MEM_PCSrc, b0.mem_stall, b0.WB_ctlwb, b0.WB_rdata, b0.WB_alu_out, b0.WB_rd};
      2: return '{b2.MEM_PCSrc, b2.mem_stall, b2.WB_ctlwb, b2.WB_rdata, b2.WB_alu_out, b2.WB_rd};
      default: return '{b3.MEM_PCSrc, b3.mem_stall, b3.WB_ctlwb, b3.WB_rdata, b3.WB_alu_out, b3.WB_rd};
    endcase
  endfunction

  // One instruction: an access occupies n+1 cycles, the last of which delivers the single WB result
  task automatic run(input int s, input int n, input logic [1:0] cw, input logic [2:0] cm,
                     input logic [31:0] a, input logic [31:0] d, input logic z, input logic [4:0] r);
    int k, cyc;
    out_t o;
    k = int'((a >> 2) % 256);
    cyc = ((cm[1] || cm[0]) && n > 0) ? n + 1 : 1;
    @(negedge clk);
    drive(s, cw, cm, a, d, z, r);
    for (int c = 0; c < cyc; c++) begin
      if (c > 0) @(negedge clk);
      #1 o = outs(s);
      if (c == 0) chk($sformatf("w%0d pcsrc", s), 32'(o.pc), 32'(cm[2] & z));
      chk($sformatf("w%0d stall c%0d", s, c), 32'(o.st), 32'(c < cyc - 1));
      @(posedge clk);
      #1 o = outs(s);
      chk($sformatf("w%0d ctlwb c%0d", s, c), 32'(o.cw), 32'(c < cyc - 1 ? 2'b00 : cw));
    end
    chk($sformatf("w%0d alu", s), o.alu, a);
    chk($sformatf("w%0d rd", s), 32'(o.rd), 32'(r));
    if (cm[1] && v[s][k]) chk($sformatf("w%0d rdata", s), o.rdat, m[s][k]);
    if (cm[0]) begin
      m[s][k] = d;
      v[s][k] = 1'b1;
    end
  endtask

  task automatic run_rand(input int s, input int n);
    logic [31:0] a;
    a = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 7)) << 2);
    run(s, n, 2'($urandom()), 3'($urandom()), a, $urandom(), 1'($urandom()), 5'($urandom()));
  endtask

  initial begin
    out_t o;
    tbl[0] = '{2'b00, 3'b001, 32'h10,  32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 32'h0};
    tbl[1] = '{2'b11, 3'b010, 32'h10,  32'h0,        1'b0, 5'd5, 1'b0, 2'b11, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{2'b00, 3'b100, 32'h0,   32'h0,        1'b1, 5'd0, 1'b1, 2'b00, 1'b0, 32'h0};
    tbl[3] = '{2'b01, 3'b100, 32'h4,   32'h0,        1'b0, 5'd1, 1'b0, 2'b01, 1'b0, 32'h0};
    tbl[4] = '{2'b00, 3'b001, 32'h400, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 32'h0};
    tbl[5] = '{2'b10, 3'b010, 32'h0,   32'h0,        1'b0, 5'd7, 1'b0, 2'b10, 1'b1, 32'hCAFEF00D};
    tbl[6] = '{2'b11, 3'b010, 32'h10,  32'h0,        1'b0, 5'd6, 1'b0, 2'b11, 1'b1, 32'hDEADBEEF};
    tbl[7] = '{2'b00, 3'b011, 32'h10,  32'h11112222, 1'b0, 5'd3, 1'b0, 2'b00, 1'b1, 32'hDEADBEEF};
    tbl[8] = '{2'b11, 3'b010, 32'h10,  32'h0,        1'b0, 5'd4, 1'b0, 2'b11, 1'b1, 32'h11112222};
`ifdef MISALIGN_TRAP_EN
    tbl[9] = '{2'b11, 3'b010, 32'h13,  32'h0,        1'b0, 5'd8, 1'b0, 2'b00, 1'b1, 32'h11112222};
`else
    tbl[9] = '{2'b11, 3'b010, 32'h13,  32'h0,        1'b0, 5'd8, 1'b0, 2'b11, 1'b1, 32'h11112222};
`endif
    drive(0, 2'b11, 3'b111, $urandom(), $urandom(), 1'b1, 5'($urandom()));
    drive(2, 2'b11, 3'b111, $urandom(), $urandom(), 1'b1, 5'($urandom()));
    drive(3, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s <= 2; s += 2) begin
      o = outs(s);
      chk($sformatf("rst w%0d pcsrc", s), 32'(o.pc), 32'h0);
      chk($sformatf("rst w%0d stall", s), 32'(o.st), 32'h0);
      chk($sformatf("rst w%0d ctlwb", s), 32'(o.cw), 32'h0);
      chk($sformatf("rst w%0d rdata", s), o.rdat, 32'h0);
      chk($sformatf("rst w%0d alu", s), o.alu, 32'h0);
      chk($sformatf("rst w%0d rd", s), 32'(o.rd), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rst3 = 1'b1;
    drive(0, 2'b10, 3'b000, 32'h1234, 32'h0, 1'b0, 5'd17);
    drive(2, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    @(posedge clk);
    #1 o = outs(0);
    chk("post-rst ctlwb", 32'(o.cw), 32'h2);
    chk("post-rst alu", o.alu, 32'h1234);
    chk("post-rst rd", 32'(o.rd), 32'd17);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(0, tbl[i].cw, tbl[i].cm, tbl[i].a, tbl[i].d, tbl[i].z, tbl[i].r);
      #1 o = outs(0);
      chk($sformatf("vec%0d pcsrc", i), 32'(o.pc), 32'(tbl[i].e_pc));
      chk($sformatf("vec%0d stall", i), 32'(o.st), 32'h0);
      @(posedge clk);
      #1 o = outs(0);
      chk($sformatf("vec%0d ctlwb", i), 32'(o.cw), 32'(tbl[i].e_cw));
      chk($sformatf("vec%0d alu", i), o.alu, tbl[i].a);
      chk($sformatf("vec%0d rd", i), 32'(o.rd), 32'(tbl[i].r));
      if (tbl[i].rchk) chk($sformatf("vec%0d rdata", i), o.rdat, tbl[i].e_rdat);
    end

`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    drive(0, 2'b00, 3'b001, 32'h13, 32'h55555555, 1'b0, 5'd0);
    @(posedge clk);
    #1 chk("misalign pulse", 32'(b0.mem_misalign), 32'h1);
    @(negedge clk);
    drive(0, 2'b11, 3'b010, 32'h10, 32'h0, 1'b0, 5'd2);
    @(posedge clk);
    #1 chk("misalign clear", 32'(b0.mem_misalign), 32'h0);
    chk("misalign mem kept", b0.WB_rdata, 32'h11112222);
`endif

    for (int k = 0; k < 256; k++) v[0][k] = 1'b0;
    for (int i = 0; i < 200; i++) run_rand(0, 0);

    run(2, 2, 2'b00, 3'b001, 32'h20, 32'h0BADF00D, 1'b0, 5'd0);
    run(2, 2, 2'b11, 3'b010, 32'h20, 32'h0, 1'b0, 5'd5);
    run(2, 2, 2'b00, 3'b100, 32'h0, 32'h0, 1'b1, 5'd0);
    for (int i = 0; i < 60; i++) run_rand(2, 2);

    run(3, 3, 2'b00, 3'b001, 32'h40, 32'hAAAA5555, 1'b0, 5'd0);
    @(negedge clk);
    drive(3, 2'b00, 3'b001, 32'h40, 32'h12345678, 1'b0, 5'd0);
    #1 chk("w3 abort stall start", 32'(b3.mem_stall), 32'h1);
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    #1 chk("w3 abort stall drop", 32'(b3.mem_stall), 32'h0);
    chk("w3 abort ctlwb", 32'(b3.WB_ctlwb), 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(3, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0);
    rst3 = 1'b1;
    #1 chk("w3 idle after rst", 32'(b3.mem_stall), 32'h0);
    run(3, 3, 2'b11, 3'b010, 32'h40, 32'h0, 1'b0, 5'd9);
    for (int i = 0; i < 30; i++) run_rand(3, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth pipeline stage; consumes the EX/MEM register outputs of the execute stage and owns the data memory.
- Resolves branches back to the fetch stage via MEM_PCSrc.
- Performs word loads and stores with optional wait states.
- Registers results into the MEM/WB pipeline register for the writeback mux and the register file.

Parameters:
- DEPTH, 256: data memory size in 32-bit words; power of two.
- ADDR_W, 8: word-index width, equal to log2(DEPTH).
- WAIT_STATES, 0: extra cycles per load/store access; 0 gives a single-cycle access.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MEM_ctlwb  in  2  {RegWrite, MemtoReg} from EX/MEM.
- MEM_ctlm  in  3  {Branch, MemRead, MemWrite} from EX/MEM.
- MEM_alu_out  in  32  ALU result; byte address for loads and stores.
- MEM_rd2  in  32  store data.
- MEM_alu_zero  in  1  ALU zero flag.
- MEM_rd  in  5  destination register index.
- MEM_PCSrc  out  1  branch taken, to fetch; fetch uses MEM_bpc directly.
- mem_stall  out  1  high while a multi-cycle access is in progress; upstream stages hold.
- WB_ctlwb  out  2  registered {RegWrite, MemtoReg}.
- WB_rdata  out  32  registered load data.
- WB_alu_out  out  32  registered ALU result.
- WB_rd  out  5  registered destination index.

Behaviour:
- Reset (rst_n low, asynchronous): all WB_* outputs = 0, FSM = IDLE, wait counter = 0, mem_stall = 0.
- Memory contents are not reset.
- MEM_PCSrc = MEM_ctlm[2] & MEM_alu_zero, combinational. It is forced to 0 while rst_n is low.
- Address decode: word index = MEM_alu_out[ADDR_W+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so addresses wrap modulo DEPTH.
- An access is active when MEM_ctlm[1] | MEM_ctlm[0] is set.
- If MemRead and MemWrite are both set, it is treated as a write. WB_rdata returns the old memory word.
- WAIT_STATES = 0:
  - No FSM activity; mem_stall stays 0.
  - Store: memory is written on the rising edge.
  - Load: WB_rdata <= mem[index] on the same edge, giving 1-cycle latency into WB.
  - Every cycle: WB_ctlwb, WB_alu_out and WB_rd load from the inputs.
- WAIT_STATES = N > 0, FSM states IDLE and BUSY:
  - IDLE with an access present: go to BUSY, counter <= N, mem_stall = 1 combinationally that cycle. WB_ctlwb <= 0 (bubble). No memory write yet.
  - BUSY: mem_stall = 1 and the counter decrements each edge. WB_ctlwb <= 0 each stalled cycle.
  - BUSY with counter = 1: mem_stall = 0. On that edge the store commits or the load data is captured, the full WB register loads, and the FSM returns to IDLE.
  - Total access = N+1 cycles. Exactly one WB result with non-zero ctlwb is produced per access.
  - Inputs must stay stable while mem_stall = 1; upstream guarantees this.
  - IDLE with no access: pass-through as for WAIT_STATES = 0.
- Load followed by a store to the same word in the next instruction: the store sees the memory state after the load. No hazard exists inside the stage.
- Reset asserted mid-access:
  - FSM returns to IDLE and the pending store is discarded; memory is unchanged.
  - mem_stall drops immediately.
- Branch instructions never stall, because they carry no access.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output mem_misalign (1 bit), registered, reset 0.
  - It is set for one cycle when an access completes with MEM_alu_out[1:0] != 0.
  - A misaligned store is suppressed (no memory write).
  - A misaligned load produces WB_ctlwb = 0, so no register write occurs.
- Undefined: no extra port; low address bits are silently ignored as above.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> all WB_* = 0, mem_stall = 0, MEM_PCSrc = 0. Release -> first edge passes inputs through.
- Store then load (WAIT_STATES = 0): store MEM_alu_out = 0x10, MEM_rd2 = 0xDEADBEEF. Next cycle load 0x10 with ctlwb = 2'b11, MEM_rd = 5 -> WB_rdata = 0xDEADBEEF, WB_rd = 5, WB_ctlwb = 2'b11 one edge later.
- Branch: ctlm = 3'b100 with alu_zero = 1 -> MEM_PCSrc = 1 the same cycle. With alu_zero = 0 -> MEM_PCSrc = 0. WB_ctlwb loads 0 when ctlwb = 0.
- Wait states (WAIT_STATES = 2): load 0x20 -> mem_stall high for 2 cycles with WB_ctlwb = 0, then WB_rdata valid on the 3rd edge and mem_stall = 0 on that cycle.
- Address wrap (DEPTH = 256): store at 0x400 then load at 0x000 -> same word is returned.
- Reset mid-access (WAIT_STATES = 3): start a store of 0x12345678 to 0x40, assert rst_n low after 1 cycle -> memory at 0x40 keeps its old value, FSM is IDLE, mem_stall = 0.
- With MISALIGN_TRAP_EN: store to 0x13 -> mem_misalign pulses once and memory is unchanged.
